modn_counter: RTL
=================

// Module: modn_counter
//
// PURPOSE
//   Parametrised modulo-N up/down counter with synchronous load and a cascade carry.
//   Generalises the fixed decade down-counter: any width, modulus and start value,
//   plus runtime direction, parallel load and pause.
//   Sits under the timer/clock-display logic. Chain digits by feeding one stage's
//   tc into the next stage's tick.
//
// PARAMETERS
//   WIDTH    4   counter register width in bits
//   MODULUS  10  number of states; value runs 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
//   START    9   reset value; must satisfy START < MODULUS
//
// PORTS
//   clk         in   1      system clock; all state changes on posedge clk
//   reset       in   1      synchronous, active-high reset
//   enable      in   1      1 = counting allowed; 0 = hold (load still honoured)
//   tick        in   1      count strobe, one clk wide; qualifies each step
//   up          in   1      1 = count up, 0 = count down; sampled per step
//   load        in   1      synchronous parallel load request
//   load_value  in   WIDTH  value applied on load
//   value       out  WIDTH  current count, registered
//   tc          out  1      combinational terminal count: enable & tick & (value at end for direction)
//   wrap        out  1      registered one-cycle pulse, asserted the cycle after a wrap occurs
//
// BEHAVIOUR
//   - Reset: value=START, wrap=0. Priority on each edge: reset > load > step > hold.
//   - Step occurs when enable & tick & !load:
//       up=1: value==MODULUS-1 -> 0, wrap<=1; otherwise value+1.
//       up=0: value==0 -> MODULUS-1, wrap<=1; otherwise value-1.
//   - Load: value<=load_value; if load_value>=MODULUS, value<=MODULUS-1 (clamp).
//     A load does not pulse wrap. Load works even when enable=0.
//   - wrap is 0 on every cycle not immediately following a wrap step. It is exactly 1 clk
//     wide, even with tick held high continuously.
//   - tc end value: MODULUS-1 when up=1, 0 when up=0. tc is combinational and valid in
//     the same cycle as the wrapping step. Next stage: tick=tc of the previous stage,
//     enable shared. Ripple depth is one AND per digit.
//   - Direction may change on any cycle. The new direction applies to that cycle's step.
//     No extra latency.
//   - Counter arithmetic is WIDTH bits, with no intermediate overflow. When
//     MODULUS==2**WIDTH, the wrap compare still uses MODULUS-1, i.e. all-ones.
//   - Reset mid-count: value=START on the next edge, wrap=0, regardless of tick or load.
//   - Illegal parameters (MODULUS<2, MODULUS>2**WIDTH, START>=MODULUS) cause an
//     elaboration failure via a generate-time check. There is no silent truncation.
//
// CONFIGURATION
//   MODN_COUNTER_ONESHOT_EN defined:
//     - Adds port oneshot (in, 1) and output done (out, 1, reset 0).
//     - With oneshot=1, a step from the end value does not wrap. value holds at the
//       end value, done<=1 (sticky), and further ticks are ignored.
//     - wrap and tc are suppressed while done=1.
//     - done clears on reset or load.
//     - With oneshot=0 the behaviour is identical to the macro being undefined.
//   Undefined: neither port exists; the counter always wraps.
//
// TESTING
//   1. Defaults, up=0, tick every cycle from reset -> value 9,8,...,0,9. tc high with value=0.
//      wrap=1 the cycle value becomes 9.
//   2. WIDTH=3, MODULUS=6, START=0, up=1, 7 ticks -> 1,2,3,4,5,0,1. Single wrap pulse
//      after 5->0.
//   3. At value=4, load=1, load_value=12, simultaneous tick (defaults) -> value=9, no wrap.
//      Then enable=0 with ticks -> value stays 9.
//   4. Two instances chained (units tc -> tens tick), up=1, 0 start, 100 ticks ->
//      tens:units go 00..99..00. Tens wrap exactly once.
//   5. Reset asserted at value=3 with tick and load both high -> value=START next cycle,
//      wrap=0.
//   6. ONESHOT_EN, oneshot=1, down from 2 -> 1,0,0,0. done=1 sticky, no wrap.
//      Then load 5 -> done=0, counting resumes 4,3.

Source files
------------

// File: rtl/modn_counter.sv
// modn_counter: modulo-N up/down counter with synchronous load, cascade carry and wrap pulse.
// Optional one-shot (stop at end value) mode is built when MODN_COUNTER_ONESHOT_EN is defined.
module modn_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10,
   parameter int unsigned START   = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             tick,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             tc,
   output logic             wrap
`ifdef MODN_COUNTER_ONESHOT_EN
   ,
   input  logic             oneshot,
   output logic             done
`endif
);

   if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH)) || (START >= MODULUS)) begin : g_param_check
      $error("modn_counter: illegal WIDTH/MODULUS/START combination");
   end

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
   // One extra bit so MODULUS == 2**WIDTH is representable in the clamp compare
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_value;
   logic [WIDTH-1:0] w_next;
   logic             r_wrap;
   logic             w_wrap_next;
   logic             w_at_end;
   logic             w_over;
   logic             w_step;
   logic             w_block;
   logic             w_hold_end;

`ifdef MODN_COUNTER_ONESHOT_EN
   logic r_done;
   logic w_done_next;

   assign w_block    = r_done;
   assign w_hold_end = oneshot;
   assign done       = r_done;
`else
   assign w_block    = 1'b0;
   assign w_hold_end = 1'b0;
`endif

   assign w_at_end = up ? (r_value == LAST) : (r_value == '0);
   assign w_over   = {1'b0, load_value} >= MOD_EXT;
   assign w_step   = enable & tick & ~load & ~w_block;
   assign tc       = enable & tick & w_at_end & ~w_block;
   assign value    = r_value;
   assign wrap     = r_wrap;

   always_comb begin
      w_next      = r_value;
      w_wrap_next = 1'b0;
`ifdef MODN_COUNTER_ONESHOT_EN
      w_done_next = r_done;
`endif
      if (load) begin
         w_next = w_over ? LAST : load_value;
`ifdef MODN_COUNTER_ONESHOT_EN
         w_done_next = 1'b0;
`endif
      end else if (w_step) begin
         if (w_at_end) begin
            if (w_hold_end) begin
`ifdef MODN_COUNTER_ONESHOT_EN
               w_done_next = 1'b1;
`endif
            end else begin
               w_next      = up ? '0 : LAST;
               w_wrap_next = 1'b1;
            end
         end else begin
            w_next = up ? (r_value + WIDTH'(1)) : (r_value - WIDTH'(1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= START_V;
         r_wrap  <= 1'b0;
`ifdef MODN_COUNTER_ONESHOT_EN
         r_done  <= 1'b0;
`endif
      end else begin
         r_value <= w_next;
         r_wrap  <= w_wrap_next;
`ifdef MODN_COUNTER_ONESHOT_EN
         r_done  <= w_done_next;
`endif
      end
   end

endmodule
